// File: rtl/counter_mux_onehot2bin_pkg.sv
// counter_mux_onehot2bin_pkg
//   Shared constants and width helper for the counter / mux / one-hot converter slice.
//   SEL_ONEHOT, SEL_BINARY : values of the mux SelectCode parameter.
//   clog2Min1()            : ceil(log2(n)), never less than 1, for index widths.
package counter_mux_onehot2bin_pkg;

    localparam int unsigned SEL_ONEHOT = 1;
    localparam int unsigned SEL_BINARY = 0;

    function automatic int unsigned clog2Min1(input int unsigned n);
        return (n <= 1) ? 1 : int'($clog2(n));
    endfunction

endpackage

// File: rtl/counter_mux_onehot2bin_if.sv
// counter_mux_onehot2bin_if
//   Bundles the data/control signals of the counter, mux and one-hot converter.
//   master : drives Set, Load, Enable, In, Select, Input, OneHot; observes Count, Output, Bin.
//   slave  : the design side (counter_mux_onehot2bin).
//   Parameters must match those of the counter_mux_onehot2bin instance it connects to.
interface counter_mux_onehot2bin_if #(
    parameter int unsigned CWidth     = 8,
    parameter int unsigned MWidth     = 4,
    parameter int unsigned NPorts     = 8,
    parameter int unsigned SelectCode = 1,
    parameter int unsigned OHWidth    = 8
);
    import counter_mux_onehot2bin_pkg::*;

    localparam int unsigned SelWidth = (SelectCode == SEL_ONEHOT) ? NPorts : clog2Min1(NPorts);
    localparam int unsigned BinWidth = clog2Min1(OHWidth);

    // Counter
    logic                     Set;
    logic                     Load;
    logic                     Enable;
    logic [CWidth-1:0]        In;
    logic [CWidth-1:0]        Count;
    // Mux
    logic [SelWidth-1:0]      Select;
    logic [NPorts*MWidth-1:0] Input;
    logic [MWidth-1:0]        Output;
    // One-hot to binary
    logic [OHWidth-1:0]       OneHot;
    logic [BinWidth-1:0]      Bin;

    modport master (
        output Set, Load, Enable, In, Select, Input, OneHot,
        input  Count, Output, Bin
    );

    modport slave (
        input  Set, Load, Enable, In, Select, Input, OneHot,
        output Count, Output, Bin
    );

endinterface

// File: rtl/counter_mux_onehot2bin_counter.sv
// counter_mux_onehot2bin_counter
//   Loadable up-counter, priority Reset > Set > Load > Enable > hold, wraps modulo 2^CWidth.
//   Clock  : rising-edge clock
//   Reset  : asynchronous active-high clear
//   Set    : load all ones
//   Load   : load In
//   Enable : increment by one
//   In     : load value
//   Count  : registered count
module counter_mux_onehot2bin_counter #(
    parameter int unsigned CWidth = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Set,
    input  logic              Load,
    input  logic              Enable,
    input  logic [CWidth-1:0] In,
    output logic [CWidth-1:0] Count
);

    logic [CWidth-1:0] countQ;
    logic [CWidth-1:0] countD;

    // In is only looked at under Load, so an unknown In cannot leak into the count.
    always_comb begin
        countD = countQ;
        if (Set) begin
            countD = '1;
        end else if (Load) begin
            countD = In;
        end else if (Enable) begin
            countD = countQ + CWidth'(1);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            countQ <= '0;
        end else begin
            countQ <= countD;
        end
    end

    assign Count = countQ;

endmodule

// File: rtl/counter_mux_onehot2bin_mux.sv
// counter_mux_onehot2bin_mux
//   Combinational N-port mux over a flattened input bus.
//   Select : one-hot (ORs every selected port) or binary index (0 when out of range)
//   Input  : port i at [MWidth*(i+1)-1 : MWidth*i]
//   Output : selected data
module counter_mux_onehot2bin_mux
    import counter_mux_onehot2bin_pkg::*;
#(
    parameter int unsigned MWidth     = 4,
    parameter int unsigned NPorts     = 8,
    parameter int unsigned SelectCode = 1,
    localparam int unsigned SelWidth  = (SelectCode == SEL_ONEHOT) ? NPorts : clog2Min1(NPorts)
) (
    input  logic [SelWidth-1:0]      Select,
    input  logic [NPorts*MWidth-1:0] Input,
    output logic [MWidth-1:0]        Output
);

    if (SelectCode == SEL_BINARY) begin : gBinary
        // Indices with no matching port leave Output at zero.
        always_comb begin
            Output = '0;
            for (int i = 0; i < int'(NPorts); i++) begin
                if (Select == SelWidth'(i)) begin
                    Output = Input[i*MWidth +: MWidth];
                end
            end
        end
    end else begin : gOneHot
        // Multiple select bits deliberately OR their ports together.
        always_comb begin
            Output = '0;
            for (int i = 0; i < int'(NPorts); i++) begin
                if (Select[i]) begin
                    Output = Output | Input[i*MWidth +: MWidth];
                end
            end
        end
    end

endmodule

// File: rtl/counter_mux_onehot2bin_onehot2bin.sv
// counter_mux_onehot2bin_onehot2bin
//   Combinational one-hot to binary index converter.
//   OneHot : input vector
//   Bin    : OR of the indices of all set bits (0 when none set; no priority encoding)
module counter_mux_onehot2bin_onehot2bin
    import counter_mux_onehot2bin_pkg::*;
#(
    parameter int unsigned OHWidth   = 8,
    localparam int unsigned BinWidth = clog2Min1(OHWidth)
) (
    input  logic [OHWidth-1:0]  OneHot,
    output logic [BinWidth-1:0] Bin
);

    always_comb begin
        Bin = '0;
        for (int i = 0; i < int'(OHWidth); i++) begin
            if (OneHot[i]) begin
                Bin = Bin | BinWidth'(i);
            end
        end
    end

endmodule

// File: rtl/counter_mux_onehot2bin.sv
// counter_mux_onehot2bin
//   Thin wrapper around three independent blocks: counter, mux, one-hot converter.
//   Clock : counter clock (rising edge)
//   Reset : asynchronous active-high counter clear; mux and converter ignore it
//   bus   : slave side of counter_mux_onehot2bin_if carrying all data/control signals
module counter_mux_onehot2bin #(
    parameter int unsigned CWidth     = 8,
    parameter int unsigned MWidth     = 4,
    parameter int unsigned NPorts     = 8,
    parameter int unsigned SelectCode = 1,
    parameter int unsigned OHWidth    = 8
) (
    input logic                     Clock,
    input logic                     Reset,
    counter_mux_onehot2bin_if.slave bus
);

    counter_mux_onehot2bin_counter #(
        .CWidth (CWidth)
    ) uCounter (
        .Clock  (Clock),
        .Reset  (Reset),
        .Set    (bus.Set),
        .Load   (bus.Load),
        .Enable (bus.Enable),
        .In     (bus.In),
        .Count  (bus.Count)
    );

    counter_mux_onehot2bin_mux #(
        .MWidth     (MWidth),
        .NPorts     (NPorts),
        .SelectCode (SelectCode)
    ) uMux (
        .Select (bus.Select),
        .Input  (bus.Input),
        .Output (bus.Output)
    );

    counter_mux_onehot2bin_onehot2bin #(
        .OHWidth (OHWidth)
    ) uOneHot2Bin (
        .OneHot (bus.OneHot),
        .Bin    (bus.Bin)
    );

endmodule

// File: tb/tb_counter_mux_onehot2bin.sv
// tb_counter_mux_onehot2bin
//   Three instances: default one-hot build, a binary-select build, and a minimum-width build
//   (NPorts=1 binary select, OHWidth=1). Expected values go into a queue as stimulus is applied
//   and are popped when the corresponding output is sampled.
module tb_counter_mux_onehot2bin;

    logic Clock;
    logic Reset;

    int checks;
    int failures;

    logic [31:0] expQ[$];
    logic [31:0] exp;

    counter_mux_onehot2bin_if mainIf ();
    counter_mux_onehot2bin_if #(.SelectCode(0)) binIf ();
    counter_mux_onehot2bin_if #(.NPorts(1), .SelectCode(0), .OHWidth(1)) edgeIf ();

    counter_mux_onehot2bin uMain (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (mainIf)
    );

    counter_mux_onehot2bin #(
        .SelectCode (0)
    ) uBin (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (binIf)
    );

    counter_mux_onehot2bin #(
        .NPorts     (1),
        .SelectCode (0),
        .OHWidth    (1)
    ) uEdge (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (edgeIf)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        // Reset is already asserted from time 0.
        #3;
        expQ.push_back(32'h00);
        exp = expQ.pop_front();
        checks++;
        if (32'(mainIf.Count) !== exp) begin
            failures++;
            $display("FAIL reset_state: Count got %h want %h", mainIf.Count, exp[7:0]);
        end

        // Output and Bin follow their inputs while Reset is held.
        mainIf.OneHot = 8'h10;
        expQ.push_back(32'h4);
        #1;
        exp = expQ.pop_front();
        checks++;
        if (32'(mainIf.Bin) !== exp) begin
            failures++;
            $display("FAIL bin_during_reset: Bin got %h want %h", mainIf.Bin, exp[2:0]);
        end
        mainIf.OneHot = '0;

        tick();
        Reset = 1'b0;
        mainIf.Load = 1'b1;
        mainIf.In = 8'h5A;
        expQ.push_back(32'h5A);
        tick();
        mainIf.Load = 1'b0;
        exp = expQ.pop_front();
        checks++;
        if (32'(mainIf.Count) !== exp) begin
            failures++;
            $display("FAIL load_5a: Count got %h want %h", mainIf.Count, exp[7:0]);
        end

        // Mid-cycle assertion must clear before any clock edge.
        #2;
        Reset = 1'b1;
        expQ.push_back(32'h00);
        #1;
        exp = expQ.pop_front();
        checks++;
        if (32'(mainIf.Count) !== exp) begin
            failures++;
            $display("FAIL async_reset: Count got %h want %h", mainIf.Count, exp[7:0]);
        end

        mainIf.Set = 1'b1;
        mainIf.Load = 1'b1;
        mainIf.Enable = 1'b1;
        mainIf.In = 8'h77;
        expQ.push_back(32'h00);
        tick();
        exp = expQ.pop_front();
        checks++;
        if (32'(mainIf.Count) !== exp) begin
            failures++;
            $display("FAIL reset_overrides: Count got %h want %h", mainIf.Count, exp[7:0]);
        end

        mainIf.Set = 1'b0;
        mainIf.Load = 1'b0;
        Reset = 1'b0;
        expQ.push_back(32'h03);
        repeat (3) tick();
        mainIf.Enable = 1'b0;
        exp = expQ.pop_front();
        checks++;
        if (32'(mainIf.Count) !== exp) begin
            failures++;
            $display("FAIL reset_then_inc3: Count got %h want %h", mainIf.Count, exp[7:0]);
        end
    endtask

    task automatic test_priority_wrap();
        logic       setV  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       loadV [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic       enV   [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0] inV   [8] = '{8'hFE, 8'h00, 8'h00, 8'h33, 8'h12, 8'hxx, 8'hxx, 8'hA5};
        logic [7:0] wantV [8] = '{8'hFE, 8'hFF, 8'h00, 8'h33, 8'hFF, 8'hFF, 8'h00, 8'hA5};
        for (int s = 0; s < 8; s++) begin
            mainIf.Set = setV[s];
            mainIf.Load = loadV[s];
            mainIf.Enable = enV[s];
            mainIf.In = inV[s];
            expQ.push_back(32'(wantV[s]));
            tick();
            exp = expQ.pop_front();
            checks++;
            if (32'(mainIf.Count) !== exp) begin
                failures++;
                $display("FAIL priority_step%0d: Count got %h want %h", s, mainIf.Count, exp[7:0]);
            end
        end
        mainIf.Set = 1'b0;
        mainIf.Load = 1'b0;
        mainIf.Enable = 1'b0;
        mainIf.In = '0;
    endtask

    task automatic test_onehot_mux();
        logic [7:0] selV  [6] = '{8'b0000_0100, 8'h00, 8'b0000_0011, 8'h80, 8'h81, 8'hFF};
        logic [3:0] wantV [6] = '{4'd3, 4'd0, 4'd3, 4'd8, 4'd9, 4'hF};
        for (int s = 0; s < 6; s++) begin
            mainIf.Select = selV[s];
            expQ.push_back(32'(wantV[s]));
            #1;
            exp = expQ.pop_front();
            checks++;
            if (32'(mainIf.Output) !== exp) begin
                failures++;
                $display("FAIL onehot_mux sel=%b: Output got %h want %h", selV[s], mainIf.Output,
                         exp[3:0]);
            end
        end
    endtask

    task automatic test_binary_mux();
        logic [2:0] selV  [4] = '{3'd5, 3'd7, 3'd0, 3'd3};
        logic [3:0] wantV [4] = '{4'd6, 4'd8, 4'd1, 4'd4};
        for (int s = 0; s < 4; s++) begin
            binIf.Select = selV[s];
            expQ.push_back(32'(wantV[s]));
            #1;
            exp = expQ.pop_front();
            checks++;
            if (32'(binIf.Output) !== exp) begin
                failures++;
                $display("FAIL binary_mux sel=%0d: Output got %h want %h", selV[s], binIf.Output,
                         exp[3:0]);
            end
        end
    endtask

    task automatic test_onehot2bin();
        logic [7:0] ohV   [7] = '{8'h01, 8'h80, 8'h10, 8'h00, 8'h0A, 8'h06, 8'h30};
        logic [2:0] wantV [7] = '{3'd0, 3'd7, 3'd4, 3'd0, 3'd3, 3'd3, 3'd5};
        for (int s = 0; s < 7; s++) begin
            mainIf.OneHot = ohV[s];
            expQ.push_back(32'(wantV[s]));
            #1;
            exp = expQ.pop_front();
            checks++;
            if (32'(mainIf.Bin) !== exp) begin
                failures++;
                $display("FAIL onehot2bin oh=%h: Bin got %h want %h", ohV[s], mainIf.Bin,
                         exp[2:0]);
            end
        end
    endtask

    task automatic test_edge_width();
        edgeIf.OneHot = 1'b1;
        expQ.push_back(32'h0);
        #1;
        exp = expQ.pop_front();
        checks++;
        if (32'(edgeIf.Bin) !== exp) begin
            failures++;
            $display("FAIL edge_bin: Bin got %h want %h", edgeIf.Bin, exp[0]);
        end

        edgeIf.Input = 4'hA;
        edgeIf.Select = 1'b0;
        expQ.push_back(32'hA);
        #1;
        exp = expQ.pop_front();
        checks++;
        if (32'(edgeIf.Output) !== exp) begin
            failures++;
            $display("FAIL edge_mux_port0: Output got %h want %h", edgeIf.Output, exp[3:0]);
        end

        // Index 1 is beyond the single port.
        edgeIf.Select = 1'b1;
        expQ.push_back(32'h0);
        #1;
        exp = expQ.pop_front();
        checks++;
        if (32'(edgeIf.Output) !== exp) begin
            failures++;
            $display("FAIL edge_mux_oob: Output got %h want %h", edgeIf.Output, exp[3:0]);
        end
    endtask

    initial begin
        logic [31:0] ports;
        checks = 0;
        failures = 0;
        Reset = 1'b1;

        for (int i = 0; i < 8; i++) ports[i*4 +: 4] = 4'(i + 1);

        mainIf.Set = 1'b0;
        mainIf.Load = 1'b0;
        mainIf.Enable = 1'b0;
        mainIf.In = '0;
        mainIf.Select = '0;
        mainIf.Input = ports;
        mainIf.OneHot = '0;

        binIf.Set = 1'b0;
        binIf.Load = 1'b0;
        binIf.Enable = 1'b0;
        binIf.In = '0;
        binIf.Select = '0;
        binIf.Input = ports;
        binIf.OneHot = '0;

        edgeIf.Set = 1'b0;
        edgeIf.Load = 1'b0;
        edgeIf.Enable = 1'b0;
        edgeIf.In = '0;
        edgeIf.Select = '0;
        edgeIf.Input = '0;
        edgeIf.OneHot = '0;

        test_reset();
        test_priority_wrap();
        test_onehot_mux();
        test_binary_mux();
        test_onehot2bin();
        test_edge_width();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_mux_onehot2bin.md
COUNTER_MUX_ONEHOT2BIN -- requirements
Module: counter_mux_onehot2bin

Interface
REQ-001 SHALL have parameter CWidth, default 8: counter width in bits.
REQ-002 SHALL have parameter MWidth, default 4: width of each mux data port.
REQ-003 SHALL have parameter NPorts, default 8: number of mux ports.
REQ-004 SHALL have parameter SelectCode, default 1: mux select encoding, 1 = one-hot, 0 = binary.
REQ-005 SHALL have parameter OHWidth, default 8: one-hot converter input width.
REQ-006 SHALL define derived widths: SelWidth = SelectCode ? NPorts : max(1, clog2(NPorts)); BinWidth = max(1, clog2(OHWidth)).
REQ-007 SHALL have port Clock, input, 1: the single clock; all state updates on its rising edge.
REQ-008 SHALL have port Reset, input, 1: asynchronous, active-high reset.
REQ-009 SHALL have port Set, input, 1: synchronous set of Count to all ones.
REQ-010 SHALL have port Load, input, 1: synchronous load of In into Count.
REQ-011 SHALL have port Enable, input, 1: increment Count by 1.
REQ-012 SHALL have port In, input, CWidth: counter load value.
REQ-013 SHALL have port Count, output, CWidth: registered counter value.
REQ-014 SHALL have port Select, input, SelWidth: mux select.
REQ-015 SHALL have port Input, input, NPorts*MWidth: flattened mux ports; port i occupies bits [MWidth*(i+1)-1 : MWidth*i].
REQ-016 SHALL have port Output, output, MWidth: combinational mux result.
REQ-017 SHALL have port OneHot, input, OHWidth: one-hot vector.
REQ-018 SHALL have port Bin, output, BinWidth: combinational binary index.

Function
REQ-019 Counter SHALL apply priority per rising edge: Reset > Set > Load > Enable > hold.
REQ-020 Counter Enable SHALL compute Count+1 modulo 2^CWidth, so all ones wraps to 0 with no carry output.
REQ-021 Counter Set SHALL force all ones regardless of Load, Enable, or In.
REQ-022 Counter Load SHALL take In even when Enable=1 in the same cycle.
REQ-023 Counter X or unknown In SHALL be ignored unless Load=1.
REQ-024 Mux with SelectCode=1 SHALL output the bitwise OR of all ports whose Select bit is 1.
REQ-025 Mux with SelectCode=1 SHALL output 0 when Select=0; with exactly one bit set, the output is exactly that port.
REQ-026 Mux with SelectCode=0 SHALL output port Select.
REQ-027 Mux with SelectCode=0 SHALL output 0 when Select >= NPorts.
REQ-028 Mux and converter SHALL be purely combinational, with zero latency and no dependence on Clock or Reset.
REQ-029 OneHot2Bin SHALL output the index i when only OneHot[i] is set.
REQ-030 OneHot2Bin SHALL output 0 when OneHot=0; callers detect "none" separately via the OR-reduction of OneHot.
REQ-031 OneHot2Bin with multiple bits set SHALL output the bitwise OR of all set indices, with no priority encoding.
REQ-032 The three functions SHALL be mutually independent; no port of one affects another.

Reset
REQ-033 Reset assertion SHALL asynchronously force Count to 0 without waiting for a clock edge.
REQ-034 Reset SHALL hold Count at 0 while asserted, overriding Set, Load, and Enable.
REQ-035 The first rising edge after Reset deasserts SHALL apply the normal priority.
REQ-036 Output and Bin SHALL have no reset value; they track their inputs at all times, including during reset.

Structure
REQ-037 The top-level SHALL be a thin wrapper instantiating three sub-modules: Counter, Mux, OneHot2Bin.
REQ-038 Each sub-module SHALL be independently reusable with its own parameters.
REQ-039 A shared package SHALL hold a clog2-with-minimum-1 width function and the SelectCode encoding constants (SEL_ONEHOT=1, SEL_BINARY=0).
REQ-040 No typedefs beyond those constants are required.

Verification
REQ-041 Reset test: assert Reset mid-cycle with Count=0x5A -> Count=0x00 immediately, before the next edge; deassert, then Enable=1 for 3 edges -> Count=0x03.
REQ-042 Priority and wrap test: Count=0xFE, Enable=1 for 2 edges -> Count 0xFF then 0x00; Load=1, In=0x33, Enable=1 -> 0x33; Set=1, Load=1 -> 0xFF.
REQ-043 One-hot mux test, NPorts=8, MWidth=4, port i value = i+1: Select=8'b0000_0100 -> Output 3; Select=0 -> 0; Select=8'b0000_0011 -> 1|2 = 3.
REQ-044 Binary mux test, SelectCode=0, same ports: Select=5 -> Output 6; Select=7 -> Output 8.
REQ-045 OneHot2Bin test, OHWidth=8: 0x01 -> 0; 0x80 -> 7; 0x10 -> 4; 0x00 -> 0; 0x0A (bits 1,3) -> 1|3 = 3.
REQ-046 Edge-width test: OHWidth=1 -> BinWidth=1 and OneHot=1 gives Bin=0; NPorts=1 with SelectCode=0 -> SelWidth=1 and Select=0 passes port 0.
